// File: rtl/rv32_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect from EX,
// and the valid/ready instruction handoff to decode.
// master = fetch unit side, slave = memory/EX/decode environment side.
interface rv32_fetch_unit_if;
  // instruction memory request channel
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  // instruction memory response channel (in order, no backpressure)
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  // redirect from EX
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // decode handoff
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/rv32_fetch_unit.sv
// Decoupled RV32 fetch: sequential PC requests, response queue, decode handoff, redirect.
// Latency: a response in cycle N is visible to decode in cycle N+1.
// Backpressure: requests are credit-limited (queue slots + outstanding cap); decode stalls fill the queue.
// Ports: clk, rst (async, active-high), fif (rv32_fetch_unit_if.master): imem request/response,
//        redirect_valid/redirect_pc, if_valid/if_ready/if_pc/if_instr.
module rv32_fetch_unit #(
  parameter logic [31:0] PC_RESET_VALUE  = 32'h0000_0000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  rv32_fetch_unit_if.master fif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(QUEUE_DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q,  resp_pc_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [CW-1:0] out_q,      out_d;
  logic [CW-1:0] drop_q,     drop_d;

  logic [31:0] pc_mem_q    [QUEUE_DEPTH];
  logic [31:0] instr_mem_q [QUEUE_DEPTH];

  logic [CW:0] credit_use;
  logic        req_vld;
  logic        req_fire;
  logic        resp_ok;
  logic        resp_drop;
  logic        push;
  logic        if_vld;
  logic        pop;

  // Every queued entry and every in-flight request holds one queue slot, so a
  // returning response always finds room.
  assign credit_use = {1'b0, count_q} + {1'b0, out_q};
  assign req_vld    = !rst && !fif.redirect_valid &&
                      (credit_use < DEPTH_C) && (out_q < MAX_C);
  assign req_fire   = req_vld && fif.imem_req_ready;

  // A response with nothing outstanding is spurious (e.g. answers a request
  // issued before reset) and is ignored entirely.
  assign resp_ok    = fif.imem_resp_valid && (out_q != '0);
  assign resp_drop  = resp_ok && (drop_q != '0);
  assign push       = resp_ok && (drop_q == '0) && !fif.redirect_valid;

  assign if_vld     = (count_q != '0) && !fif.redirect_valid;
  assign pop        = if_vld && fif.if_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;

    if (fif.redirect_valid) begin
      // Everything still in flight (minus the response landing now, which is
      // simply discarded) belongs to the old path and must be dropped.
      fetch_pc_d = fif.redirect_pc;
      resp_pc_d  = fif.redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      out_d      = out_q - CW'(resp_ok);
      drop_d     = out_q - CW'(resp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      out_d = out_q + CW'(req_fire) - CW'(resp_ok);
      if (resp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= PC_RESET_VALUE;
      resp_pc_q  <= PC_RESET_VALUE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage needs no reset: it is only observed while count_q != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
      instr_mem_q[wr_ptr_q] <= fif.imem_resp_data;
    end
  end

  assign fif.imem_req_valid = req_vld;
  assign fif.imem_addr      = fetch_pc_q;
  assign fif.if_valid       = if_vld;
  // Head outputs read as zero while the queue is empty.
  assign fif.if_pc          = (count_q != '0) ? pc_mem_q[rd_ptr_q]    : 32'h0;
  assign fif.if_instr       = (count_q != '0) ? instr_mem_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Bench for rv32_fetch_unit: directed vector table, multi-cycle corner sequences,
// and randomized memory/decode behaviour checked against an instruction-stream model.
module tb_rv32_fetch_unit;

  logic clk;
  logic rst;
  rv32_fetch_unit_if fif ();

  rv32_fetch_unit #(
    .PC_RESET_VALUE (32'h0000_0000),
    .QUEUE_DEPTH    (4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fif(fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory model: accepted request addresses awaiting their in-order response.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  // Stream model: the next PC decode must see, and the next PC memory must be asked for.
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  bit          stall_prev;
  logic [31:0] stall_addr;
  int          ndeliv = 0;
  int          nfire = 0;
  logic [31:0] last_pc;
  bit          redir_fired;

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic [31:0] rdat;
    logic        redir;
    logic [31:0] rpc;
    logic        ifr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vt[17];

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic vec_t mk(input logic rdy, input logic rsp, input logic [31:0] rdat,
                              input logic redir, input logic [31:0] rpc, input logic ifr,
                              input logic e_req, input logic [31:0] e_addr, input logic e_ifv,
                              input logic [31:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.rdy = rdy; v.rsp = rsp; v.rdat = rdat; v.redir = redir; v.rpc = rpc; v.ifr = ifr;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    fif.imem_req_ready  = 1'b0;
    fif.imem_resp_valid = 1'b0;
    fif.imem_resp_data  = 32'h0;
    fif.redirect_valid  = 1'b0;
    fif.redirect_pc     = 32'h0;
    fif.if_ready        = 1'b0;
  endtask

  task automatic clear_model(input bit keep_pending);
    if (!keep_pending) begin
      pend_addr.delete();
      pend_due.delete();
    end
    exp_pc     = 32'h0;
    exp_req    = 32'h0;
    stall_prev = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", fif.imem_req_valid, 32'd0);
    chk("rst_if_valid",  fif.if_valid,       32'd0);
    chk("rst_if_pc",     fif.if_pc,          32'd0);
    chk("rst_if_instr",  fif.if_instr,       32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_model(1'b0);
  endtask

  // One cycle: drive memory/redirect/decode inputs, check against the stream
  // model, then advance to the next falling edge.
  // rdy_mode: 0 never ready, 1 always, 2 random. redir_mode: 0 none, 1 now,
  // 2 only when a response arrives with two requests in flight.
  task automatic step(input int rdy_mode, input int redir_mode, input logic [31:0] rpc,
                      input bit ifr);
    bit do_resp;
    bit do_redir;
    bit rdy;
    int pb;
    int d;
    pb       = pend_addr.size();
    do_resp  = (pb > 0) && (pend_due[0] <= cyc);
    rdy      = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
    do_redir = (redir_mode == 1) || (redir_mode == 2 && do_resp && pb == 2);
    fif.imem_req_ready  = rdy;
    fif.imem_resp_valid = do_resp;
    fif.imem_resp_data  = 32'h0;
    if (do_resp) fif.imem_resp_data = f(pend_addr[0]);
    fif.redirect_valid  = do_redir;
    fif.redirect_pc     = rpc;
    fif.if_ready        = ifr;
    #1;
    if (do_resp) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (do_redir) begin
      chk("redir_if_valid",  fif.if_valid,       32'd0);
      chk("redir_req_valid", fif.imem_req_valid, 32'd0);
    end
    if (stall_prev) chk("addr_stable", fif.imem_addr, stall_addr);
    if (fif.if_valid && ifr) begin
      chk("deliv_pc",    fif.if_pc,    exp_pc);
      chk("deliv_instr", fif.if_instr, f(exp_pc));
      last_pc = fif.if_pc;
      exp_pc  = exp_pc + 32'd4;
      ndeliv++;
    end
    if (fif.imem_req_valid && rdy) begin
      chk("req_addr", fif.imem_addr, exp_req);
      exp_req = exp_req + 32'd4;
      d = cyc + $urandom_range(lat_min, lat_max);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_addr.push_back(fif.imem_addr);
      pend_due.push_back(d);
      nfire++;
      chk("max_outstanding", 32'(pend_addr.size() <= 2), 32'd1);
    end
    stall_prev = fif.imem_req_valid && !rdy;
    stall_addr = fif.imem_addr;
    if (do_redir) begin
      exp_pc  = rpc;
      exp_req = rpc;
    end
    redir_fired = do_redir;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

  initial begin
    int n0;
    int g;
    //          rdy rsp rdat          redir rpc        ifr | req addr       ifv pc         instr
    vt[0]  = mk(0, 0, 32'h0,         0, 32'h0,     0,   1, 32'h0,     0, 32'h0,     32'h0);
    vt[1]  = mk(1, 0, 32'h0,         0, 32'h0,     0,   1, 32'h0,     0, 32'h0,     32'h0);
    vt[2]  = mk(1, 1, f(32'h0),      0, 32'h0,     0,   1, 32'h4,     0, 32'h0,     32'h0);
    vt[3]  = mk(0, 0, 32'h0,         0, 32'h0,     0,   1, 32'h8,     1, 32'h0,     f(32'h0));
    vt[4]  = mk(1, 1, f(32'h4),      0, 32'h0,     1,   1, 32'h8,     1, 32'h0,     f(32'h0));
    vt[5]  = mk(1, 1, f(32'h8),      0, 32'h0,     0,   1, 32'hC,     1, 32'h4,     f(32'h4));
    vt[6]  = mk(1, 0, 32'h0,         0, 32'h0,     0,   1, 32'h10,    1, 32'h4,     f(32'h4));
    vt[7]  = mk(1, 0, 32'h0,         0, 32'h0,     0,   0, 32'h14,    1, 32'h4,     f(32'h4));
    vt[8]  = mk(1, 1, f(32'hC),      1, 32'h100,   1,   0, 32'h14,    0, 32'h4,     f(32'h4));
    vt[9]  = mk(0, 1, f(32'h10),     0, 32'h0,     1,   1, 32'h100,   0, 32'h0,     32'h0);
    vt[10] = mk(1, 0, 32'h0,         0, 32'h0,     1,   1, 32'h100,   0, 32'h0,     32'h0);
    vt[11] = mk(1, 1, f(32'h100),    0, 32'h0,     1,   1, 32'h104,   0, 32'h0,     32'h0);
    vt[12] = mk(0, 0, 32'h0,         0, 32'h0,     1,   1, 32'h108,   1, 32'h100,   f(32'h100));
    vt[13] = mk(0, 1, f(32'h104),    0, 32'h0,     1,   1, 32'h108,   0, 32'h0,     32'h0);
    vt[14] = mk(0, 0, 32'h0,         0, 32'h0,     1,   1, 32'h108,   1, 32'h104,   f(32'h104));
    vt[15] = mk(0, 1, 32'hDEAD_BEEF, 0, 32'h0,     1,   1, 32'h108,   0, 32'h0,     32'h0);
    vt[16] = mk(0, 0, 32'h0,         0, 32'h0,     1,   1, 32'h108,   0, 32'h0,     32'h0);

    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      fif.imem_req_ready  = vt[i].rdy;
      fif.imem_resp_valid = vt[i].rsp;
      fif.imem_resp_data  = vt[i].rdat;
      fif.redirect_valid  = vt[i].redir;
      fif.redirect_pc     = vt[i].rpc;
      fif.if_ready        = vt[i].ifr;
      #1;
      chk($sformatf("vec%0d_req_valid", i), fif.imem_req_valid, vt[i].e_req);
      chk($sformatf("vec%0d_addr", i),      fif.imem_addr,      vt[i].e_addr);
      chk($sformatf("vec%0d_if_valid", i),  fif.if_valid,       vt[i].e_ifv);
      chk($sformatf("vec%0d_if_pc", i),     fif.if_pc,          vt[i].e_pc);
      chk($sformatf("vec%0d_if_instr", i),  fif.if_instr,       vt[i].e_instr);
      @(posedge clk);
      @(negedge clk);
    end

    // Streaming at one instruction per cycle.
    do_reset();
    lat_min = 1; lat_max = 1;
    n0 = ndeliv;
    for (int i = 0; i < 20; i++) step(1, 0, 32'h0, 1'b1);
    chk("stream_rate", ndeliv - n0, 32'd18);

    // Decode backpressure fills the queue and stops requests.
    do_reset();
    n0 = nfire;
    for (int i = 0; i < 10; i++) step(1, 0, 32'h0, 1'b0);
    chk("bp_fill_count",  nfire - n0,         32'd4);
    chk("bp_req_off",     fif.imem_req_valid, 32'd0);
    chk("bp_outstanding", pend_addr.size(),   32'd0);
    n0 = ndeliv;
    for (int i = 0; i < 5; i++) step(1, 0, 32'h0, 1'b1);
    chk("bp_no_gap", ndeliv - n0, 32'd5);
    chk("bp_last_pc", last_pc, 32'h10);

    // Redirect with two requests in flight, 3-cycle memory.
    do_reset();
    lat_min = 3; lat_max = 3;
    g = 0;
    while (pend_addr.size() != 2 && g < 10) begin step(1, 0, 32'h0, 1'b1); g++; end
    chk("redir2_inflight", pend_addr.size(), 32'd2);
    step(1, 1, 32'h100, 1'b1);
    n0 = ndeliv; g = 0;
    while (ndeliv == n0 && g < 30) begin step(1, 0, 32'h0, 1'b1); g++; end
    chk("redir2_first_pc", last_pc, 32'h100);

    // Redirect coincident with a response, two in flight.
    do_reset();
    lat_min = 2; lat_max = 2;
    redir_fired = 1'b0; g = 0;
    while (!redir_fired && g < 20) begin step(1, 2, 32'h200, 1'b1); g++; end
    chk("coinc_redirect_hit", redir_fired, 32'd1);
    n0 = ndeliv; g = 0;
    while (ndeliv < n0 + 2 && g < 30) begin step(1, 0, 32'h0, 1'b1); g++; end
    chk("coinc_second_pc", last_pc, 32'h204);

    // PC wrap-around at 2^32.
    lat_min = 1; lat_max = 1;
    step(1, 1, 32'hFFFF_FFF8, 1'b1);
    n0 = ndeliv; g = 0;
    while (ndeliv < n0 + 4 && g < 30) begin step(1, 0, 32'h0, 1'b1); g++; end
    chk("wrap_pc", last_pc, 32'h4);

    // Asynchronous reset with the queue half full.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 1'b0);
    idle_inputs();
    #1;
    chk("pre_rst_if_valid", fif.if_valid, 32'd1);
    @(posedge clk);
    cyc++;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_if_valid",  fif.if_valid,       32'd0);
    chk("async_rst_req_valid", fif.imem_req_valid, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model(1'b1);
    g = 0;
    while (pend_addr.size() > 0 && g < 20) begin step(0, 0, 32'h0, 1'b1); g++; end
    chk("post_rst_addr", fif.imem_addr, 32'h0);
    n0 = ndeliv; g = 0;
    while (ndeliv < n0 + 4 && g < 40) begin step(1, 0, 32'h0, 1'b1); g++; end
    chk("post_rst_stream", last_pc, 32'hC);

    // Randomized memory stalls, latencies, decode stalls and redirects.
    lat_min = 1; lat_max = 4;
    n0 = ndeliv;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      int rm;
      rm  = ($urandom_range(0, 31) == 0) ? 1 : 0;
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      step(2, rm, rpc, ($urandom_range(0, 3) != 0));
    end
    chk("rand_progress", 32'(ndeliv - n0 > 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
